// File: rtl/layer_sequencer.sv
// layer_sequencer: runtime scheduler for the eleven network stages
// (conv1, pool1, conv2, pool2, conv3, conv4, conv5, pool3, fc1, fc2, fc3).
// It walks the stages in order, issues one start pulse per output element,
// waits for that stage's acknowledge, counts elements against a host-written
// count table, and supports free-run, single-step and a per-element timeout.
//
// Handshake: en_vec[i] is a one-cycle start request for one element of stage
// i; the stage answers with a one-cycle ack_vec[i] pulse at least one cycle
// later. Only acks for the current stage, arriving while waiting, are counted.
module layer_sequencer #(
    parameter int CNT_W   = 16,
    parameter int DEF_CNT = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step_mode,
    input  logic             next,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic [10:0]      ack_vec,
    output logic [10:0]      en_vec,
    output logic [3:0]       stage,
    output logic [CNT_W-1:0] elem_cnt,
    output logic             busy,
    output logic             hold,
    output logic             Done,
    output logic             err
);

    localparam int NUM_STAGES = 11;
    localparam logic [3:0] LAST_STAGE = 4'd10;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_ISSUE,
        S_WAIT,
        S_ADV,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        stage_q, stage_d;
    logic [CNT_W-1:0]  elem_q, elem_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              next_q, next_d;
    logic [CNT_W-1:0]  cnt_q [NUM_STAGES];
    logic [CNT_W-1:0]  cnt_d [NUM_STAGES];
    logic [10:0]       en_vec_q, en_vec_d;
    logic              busy_q, busy_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W:0]    elem_inc;
    logic              next_rise;

    // Next-state logic: count table writes, FSM transitions and output decode
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        elem_d   = elem_q;
        err_d    = err_q;
        to_d     = to_q;
        next_d   = next;
        cnt_d    = cnt_q;
        en_vec_d = '0;
        busy_d   = 1'b0;
        hold_d   = 1'b0;
        done_d   = 1'b0;

        // Table writes land at the edge in any state; compares read the live value.
        if (cfg_we && (cfg_addr <= LAST_STAGE)) begin
            cnt_d[cfg_addr] = cfg_data;
        end

        cur_cnt   = cnt_q[stage_q];
        // One extra bit so the >= compare cannot wrap.
        elem_inc  = {1'b0, elem_q} + 1'b1;
        // Edge detector runs in every state; edges outside HOLD are simply lost.
        next_rise = next && !next_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    stage_d = '0;
                    elem_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (cur_cnt == '0) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + 4'd1;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ack_vec[stage_q]) begin
                    elem_d = elem_inc[CNT_W-1:0];
                    // >= keeps a count shrunk mid-stage from running forever.
                    if (elem_inc >= {1'b0, cur_cnt}) begin
                        state_d = S_ADV;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_ADV: begin
                if (stage_q == LAST_STAGE) begin
                    state_d = S_DONE;
                end else if (step_mode) begin
                    state_d = S_HOLD;
                end else begin
                    stage_d = stage_q + 4'd1;
                    elem_d  = '0;
                    state_d = S_CHK;
                end
            end
            S_HOLD: begin
                if (next_rise) begin
                    stage_d = stage_q + 4'd1;
                    elem_d  = '0;
                    state_d = S_CHK;
                end
            end
            S_DONE: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        if (state_d == S_ISSUE) begin
            en_vec_d[stage_d] = 1'b1;
        end
        busy_d = !(state_d inside {S_IDLE, S_DONE});
        hold_d = (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; reset aborts any run immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            elem_q   <= '0;
            err_q    <= 1'b0;
            to_q     <= '0;
            next_q   <= 1'b0;
            en_vec_q <= '0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt_q[i] <= CNT_W'(DEF_CNT);
            end
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            elem_q   <= elem_d;
            err_q    <= err_d;
            to_q     <= to_d;
            next_q   <= next_d;
            en_vec_q <= en_vec_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign en_vec   = en_vec_q;
    assign stage    = stage_q;
    assign elem_cnt = elem_q;
    assign busy     = busy_q;
    assign hold     = hold_q;
    assign Done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a responder acks one cycle after each
// start pulse, pulses are logged as {stage, cycle} and compared in order
// against hand-computed expected queues.
module tb_layer_sequencer;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             step_mode;
    logic             next;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    logic [10:0]      ack_vec;
    logic [10:0]      en_vec;
    logic [3:0]       stage;
    logic [CNT_W-1:0] elem_cnt;
    logic             busy;
    logic             hold;
    logic             Done;
    logic             err;

    layer_sequencer #(.CNT_W(CNT_W), .DEF_CNT(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .step_mode(step_mode), .next(next),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .ack_vec(ack_vec), .en_vec(en_vec), .stage(stage), .elem_cnt(elem_cnt),
        .busy(busy), .hold(hold), .Done(Done), .err(err)
    );

    // Clock
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          onehot_bad = 0;
    int          done_cycle = 0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    logic        pend_valid;
    logic [3:0]  pend_stage;
    logic [10:0] ack_mask;
    logic        shrink_armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: observe at the falling edge, log pulses, drive inputs.
    task automatic cyc();
        @(negedge clk);
        cycle++;
        cfg_we  = 1'b0;
        ack_vec = '0;
        if (pend_valid && ack_mask[pend_stage]) ack_vec[pend_stage] = 1'b1;
        pend_valid = 1'b0;
        if (!$onehot0(en_vec)) onehot_bad++;
        for (int i = 0; i < 11; i++) begin
            if (en_vec[i]) begin
                got_q.push_back({4'(i), 16'(cycle)});
                pend_valid = 1'b1;
                pend_stage = 4'(i);
            end
        end
        if (shrink_armed && stage == 4'd2 && elem_cnt == 16'd5) begin
            cfg_we       = 1'b1;
            cfg_addr     = 4'd2;
            cfg_data     = 16'd3;
            shrink_armed = 1'b0;
        end
    endtask

    task automatic write_cnt(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = CNT_W'(data);
        cyc();
    endtask

    task automatic set_all(input int data);
        for (int i = 0; i < 11; i++) write_cnt(i, data);
    endtask

    task automatic launch(output int l);
        l  = cycle;
        en = 1'b1;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n = 0;
        while (!Done && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, " reached Done"}, Done, 1);
        done_cycle = cycle;
    endtask

    task automatic wait_hold(input string tag, input int budget);
        int n = 0;
        while (!hold && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, " reached HOLD"}, hold, 1);
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, " pulse count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, " pulse"}, got_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        int n2;
        rst = 1'b0; en = 1'b0; step_mode = 1'b0; next = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ack_vec = '0;
        pend_valid = 1'b0; pend_stage = '0; ack_mask = '1; shrink_armed = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst en_vec", en_vec, 0);
        chk("rst stage", stage, 0);
        chk("rst elem_cnt", elem_cnt, 0);
        chk("rst busy", busy, 0);
        chk("rst hold", hold, 0);
        chk("rst Done", Done, 0);
        chk("rst err", err, 0);
        rst = 1'b1;
        cyc();

        // Default count 4 in step mode: four pulses in stage 0, then HOLD
        clear_logs();
        step_mode = 1'b1;
        launch(l);
        for (int k = 0; k < 4; k++) exp_q.push_back({4'd0, 16'(l + 2 + 2 * k)});
        wait_hold("t0", 60);
        check_pulses("t0");
        chk("t0 elem_cnt", elem_cnt, 4);
        chk("t0 hold cycle", cycle, l + 11);
        rst = 1'b0; en = 1'b0; step_mode = 1'b0;
        cyc();
        pend_valid = 1'b0;
        rst = 1'b1;
        cyc();

        // All counts 2, free run: 22 pulses in stage order
        set_all(2);
        clear_logs();
        launch(l);
        for (int s = 0; s < 11; s++) begin
            exp_q.push_back({4'(s), 16'(l + 2 + 6 * s)});
            exp_q.push_back({4'(s), 16'(l + 4 + 6 * s)});
        end
        run_to_done("t1", 200);
        check_pulses("t1");
        chk("t1 done cycle", done_cycle, l + 67);
        chk("t1 err", err, 0);
        chk("t1 stage", stage, 10);
        chk("t1 elem_cnt", elem_cnt, 2);
        chk("t1 busy", busy, 0);
        en = 1'b0;
        cyc();
        chk("t1 Done after en low", Done, 0);

        // Stages 1 and 10 skipped
        set_all(1);
        write_cnt(1, 0);
        write_cnt(10, 0);
        clear_logs();
        launch(l);
        exp_q.push_back({4'd0, 16'(l + 2)});
        for (int s = 2; s < 10; s++) exp_q.push_back({4'(s), 16'(l + 7 + 4 * (s - 2))});
        run_to_done("t2", 200);
        check_pulses("t2");
        chk("t2 done cycle", done_cycle, l + 39);
        chk("t2 stage", stage, 10);
        chk("t2 elem_cnt", elem_cnt, 0);
        en = 1'b0;
        cyc();

        // Single-step mode
        set_all(1);
        clear_logs();
        step_mode = 1'b1;
        launch(l);
        wait_hold("t3 first", 50);
        chk("t3 first stage", stage, 0);
        chk("t3 busy in hold", busy, 1);
        repeat (4) cyc();
        chk("t3 parked stage", stage, 0);
        next = 1'b1;
        repeat (8) cyc();
        next = 1'b0;
        repeat (4) cyc();
        chk("t3 long next stage", stage, 1);
        chk("t3 long next hold", hold, 1);
        next = 1'b1;
        repeat (5) cyc();
        next = 1'b0;
        repeat (3) cyc();
        chk("t3 5cy next stage", stage, 2);
        chk("t3 5cy next hold", hold, 1);
        next = 1'b1;
        cyc();
        next = 1'b0;
        cyc();
        cyc();
        next = 1'b1;
        cyc();
        next = 1'b0;
        repeat (4) cyc();
        chk("t3 wait next ignored stage", stage, 3);
        chk("t3 wait next ignored hold", hold, 1);
        for (int k = 0; k < 6; k++) begin
            next = 1'b1;
            cyc();
            next = 1'b0;
            wait_hold("t3 step", 20);
        end
        chk("t3 before last stage", stage, 9);
        next = 1'b1;
        cyc();
        next = 1'b0;
        run_to_done("t3", 20);
        chk("t3 final stage", stage, 10);
        chk("t3 total pulses", got_q.size(), 11);
        for (int i = 0; i < got_q.size() && i < 11; i++) chk("t3 pulse stage", got_q[i][19:16], i);
        en = 1'b0;
        step_mode = 1'b0;
        cyc();

        // Timeout on stage 3
        clear_logs();
        ack_mask = ~(11'd1 << 3);
        launch(l);
        run_to_done("t4", 100);
        chk("t4 done cycle", done_cycle, l + 23);
        chk("t4 err", err, 1);
        chk("t4 stage", stage, 3);
        chk("t4 elem_cnt", elem_cnt, 0);
        chk("t4 pulses", got_q.size(), 4);
        ack_mask = '1;
        en = 1'b0;
        cyc();
        chk("t4 err sticky in idle", err, 1);
        chk("t4 Done cleared", Done, 0);
        launch(l);
        cyc();
        chk("t4 err cleared by launch", err, 0);
        run_to_done("t4 rerun", 100);
        chk("t4 rerun err", err, 0);
        en = 1'b0;
        cyc();

        // Count shrunk mid-stage: 10 -> 3 after five acks
        write_cnt(2, 10);
        clear_logs();
        shrink_armed = 1'b1;
        launch(l);
        run_to_done("t5", 300);
        n2 = 0;
        foreach (got_q[i]) if (got_q[i][19:16] == 4'd2) n2++;
        chk("t5 stage2 pulses", n2, 6);
        chk("t5 total pulses", got_q.size(), 16);
        en = 1'b0;
        cyc();
        write_cnt(2, 1);

        // Asynchronous reset mid-WAIT of stage 4
        clear_logs();
        ack_mask = ~(11'd1 << 4);
        launch(l);
        repeat (19) cyc();
        chk("t6 stage before reset", stage, 4);
        chk("t6 busy before reset", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6 async en_vec", en_vec, 0);
        chk("t6 async stage", stage, 0);
        chk("t6 async elem_cnt", elem_cnt, 0);
        chk("t6 async busy", busy, 0);
        chk("t6 async hold", hold, 0);
        chk("t6 async Done", Done, 0);
        chk("t6 async err", err, 0);
        en = 1'b0;
        clear_logs();
        cyc();
        cyc();
        pend_valid = 1'b0;
        ack_mask = '1;
        rst = 1'b1;
        cyc();
        chk("t6 no pulses in reset", got_q.size(), 0);
        launch(l);
        repeat (3) cyc();
        chk("t6 relaunch pulses", got_q.size(), 1);
        if (got_q.size() > 0) chk("t6 relaunch first pulse", got_q[0], {4'd0, 16'(l + 2)});
        run_to_done("t6", 400);
        chk("t6 relaunch err", err, 0);
        chk("t6 relaunch pulses total", got_q.size(), 44);
        en = 1'b0;
        cyc();

        chk("en_vec one-hot", onehot_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
